// File: rtl/bp_be_dcache_lce_cmd_merge.sv
// -----------------------------------------------------------------------------
// bp_be_dcache_lce_cmd_merge
//
// Merges the two command streams that feed the D$ LCE command stage: commands
// from the CCE network and LCE-LCE transfer commands from another LCE. Each
// source lands in its own small circular-buffer FIFO. A two-state round-robin
// arbiter picks one FIFO head and presents it to the consumer.
//
// Handshake semantics, used on every port pair of this block:
//   - Inputs use valid/ready. An entry is taken in the cycle where v_i and
//     ready_o are both high. ready_o comes only from registered state, so it
//     never depends combinationally on any input. Data is ignored while v_i
//     is low.
//   - The output uses valid/yumi. lce_cmd_yumi_i may only be high while
//     lce_cmd_v_o is high, and it dequeues the presented entry in that cycle.
//     Once presented, the entry and its source stay stable until yumi.
//
// Ports:
//   clk_i, reset_n_i           clock, asynchronous active-low reset
//   cce_cmd_i/_v_i/_ready_o    CCE command input (valid/ready)
//   tr_cmd_i/_v_i/_ready_o     transfer command input (valid/ready)
//   lce_cmd_o/_v_o/_yumi_i     merged command output (valid/yumi)
//   lce_cmd_src_o              source of lce_cmd_o: 0 = CCE, 1 = transfer
//   cce_count_o, tr_count_o    FIFO occupancy
//   arb_state_o                arbiter state (IDLE / HOLD), for observation
// -----------------------------------------------------------------------------

package bp_be_dcache_lce_cmd_merge_pkg;

  // Processor configurations. Each one fixes the LCE-CCE interface widths.
  typedef enum logic [1:0] {
    e_bp_inv_cfg         = 2'd0,
    e_bp_single_core_cfg = 2'd1,
    e_bp_dual_core_cfg   = 2'd2,
    e_bp_quad_core_cfg   = 2'd3
  } bp_params_e;

  typedef enum logic {
    e_arb_idle = 1'b0,
    e_arb_hold = 1'b1
  } arb_state_e;

  // Width of an LCE command:
  //   dst lce id + msg type (4) + way id + coherence state (3) + paddr
  //   + target lce id + target way id
  function automatic int unsigned lce_cmd_width(input bp_params_e cfg);
    int unsigned num_lce;
    int unsigned lce_assoc;
    int unsigned paddr_width;
    int unsigned lce_id_width;
    int unsigned way_id_width;
    case (cfg)
      e_bp_dual_core_cfg: begin
        num_lce = 4; lce_assoc = 8; paddr_width = 40;
      end
      e_bp_quad_core_cfg: begin
        num_lce = 8; lce_assoc = 8; paddr_width = 40;
      end
      default: begin
        num_lce = 2; lce_assoc = 8; paddr_width = 40;
      end
    endcase
    lce_id_width = (num_lce > 1) ? $clog2(num_lce) : 1;
    way_id_width = (lce_assoc > 1) ? $clog2(lce_assoc) : 1;
    return 2 * lce_id_width + 2 * way_id_width + 4 + 3 + paddr_width;
  endfunction

endpackage

// -----------------------------------------------------------------------------
// Per-source circular-buffer FIFO.
//   en_i      gates ready_o; low during reset and until the first clock after
//             reset is released
//   v_i/ready_o/data_i   enqueue side (valid/ready)
//   deq_i/data_o         dequeue side; data_o is the head entry
//   count_o              occupancy, 0..els_p
// -----------------------------------------------------------------------------
module bp_be_dcache_lce_cmd_merge_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       en_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic                       deq_i,
  output logic [width_p-1:0]         data_o,
  output logic [$clog2(els_p+1)-1:0] count_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);
  localparam logic [ptr_w-1:0] last_ptr_c = ptr_w'(els_p - 1);
  localparam logic [cnt_w-1:0] els_c      = cnt_w'(els_p);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   wr_ptr_r;
  logic [ptr_w-1:0]   rd_ptr_r;
  logic [cnt_w-1:0]   count_r;
  logic               enq;

  assign ready_o = en_i & (count_r < els_c);
  assign enq     = v_i & ready_o;
  assign data_o  = mem[rd_ptr_r];
  assign count_o = count_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_r <= (wr_ptr_r == last_ptr_c) ? '0 : wr_ptr_r + ptr_w'(1);
      end
      if (deq_i) begin
        rd_ptr_r <= (rd_ptr_r == last_ptr_c) ? '0 : rd_ptr_r + ptr_w'(1);
      end
      // Simultaneous enqueue and dequeue leave the count unchanged.
      case ({enq, deq_i})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wr_ptr_r] <= data_i;
    end
  end

endmodule

// -----------------------------------------------------------------------------
// Top: two FIFOs plus the round-robin IDLE/HOLD arbiter.
// -----------------------------------------------------------------------------
module bp_be_dcache_lce_cmd_merge
  import bp_be_dcache_lce_cmd_merge_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg,
  parameter int         els_p       = 2,
  localparam int        lce_cmd_width_lp = lce_cmd_width(bp_params_p),
  localparam int        cnt_width_lp     = $clog2(els_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic [lce_cmd_width_lp-1:0] cce_cmd_i,
  input  logic                        cce_cmd_v_i,
  output logic                        cce_cmd_ready_o,

  input  logic [lce_cmd_width_lp-1:0] tr_cmd_i,
  input  logic                        tr_cmd_v_i,
  output logic                        tr_cmd_ready_o,

  output logic [lce_cmd_width_lp-1:0] lce_cmd_o,
  output logic                        lce_cmd_v_o,
  input  logic                        lce_cmd_yumi_i,
  output logic                        lce_cmd_src_o,

  output logic [cnt_width_lp-1:0]     cce_count_o,
  output logic [cnt_width_lp-1:0]     tr_count_o,
  output arb_state_e                  arb_state_o
);

  // Low during reset, high from the first clock edge after release. Keeps
  // both ready outputs low while in reset without a combinational path from
  // reset_n_i.
  logic ready_en_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  logic [lce_cmd_width_lp-1:0] cce_head;
  logic [lce_cmd_width_lp-1:0] tr_head;
  logic                        deq_cce;
  logic                        deq_tr;

  bp_be_dcache_lce_cmd_merge_fifo #(
    .width_p (lce_cmd_width_lp),
    .els_p   (els_p)
  ) cce_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (ready_en_r),
    .data_i    (cce_cmd_i),
    .v_i       (cce_cmd_v_i),
    .ready_o   (cce_cmd_ready_o),
    .deq_i     (deq_cce),
    .data_o    (cce_head),
    .count_o   (cce_count_o)
  );

  bp_be_dcache_lce_cmd_merge_fifo #(
    .width_p (lce_cmd_width_lp),
    .els_p   (els_p)
  ) tr_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (ready_en_r),
    .data_i    (tr_cmd_i),
    .v_i       (tr_cmd_v_i),
    .ready_o   (tr_cmd_ready_o),
    .deq_i     (deq_tr),
    .data_o    (tr_head),
    .count_o   (tr_count_o)
  );

  // Arbiter state.
  //   grant_r      source locked while in HOLD
  //   last_grant_r source of the most recent dequeue; resets to 1 so the CCE
  //                source wins the first tie
  arb_state_e state_r;
  arb_state_e state_n;
  logic       grant_r;
  logic       last_grant_r;

  logic       cce_ne;
  logic       tr_ne;
  logic       sel;
  logic       cmd_v;
  logic       deq;

  assign cce_ne = (cce_count_o != '0);
  assign tr_ne  = (tr_count_o != '0);

  always_comb begin
    sel     = 1'b0;
    cmd_v   = 1'b0;
    state_n = state_r;
    case (state_r)
      e_arb_idle: begin
        cmd_v = cce_ne | tr_ne;
        if (cce_ne && tr_ne) begin
          sel = ~last_grant_r;
        end else if (tr_ne) begin
          sel = 1'b1;
        end else begin
          sel = 1'b0;
        end
      end
      e_arb_hold: begin
        // The locked head cannot have been dequeued, so it is still present.
        cmd_v = 1'b1;
        sel   = grant_r;
      end
      default: begin
        cmd_v = 1'b0;
        sel   = 1'b0;
      end
    endcase

    // yumi without a presented command is ignored, leaving state unchanged.
    deq = cmd_v & lce_cmd_yumi_i;

    if (cmd_v && !lce_cmd_yumi_i) begin
      state_n = e_arb_hold;
    end else begin
      state_n = e_arb_idle;
    end
  end

  assign deq_cce = deq & ~sel;
  assign deq_tr  = deq & sel;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= e_arb_idle;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      state_r <= state_n;
      if (cmd_v && !lce_cmd_yumi_i) begin
        grant_r <= sel;
      end
      if (deq) begin
        last_grant_r <= sel;
      end
    end
  end

  assign lce_cmd_o     = sel ? tr_head : cce_head;
  assign lce_cmd_v_o   = cmd_v;
  assign lce_cmd_src_o = sel;
  assign arb_state_o   = state_r;

  // The consumer must never take a command that is not presented.
  yumi_without_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
      !(lce_cmd_yumi_i && !lce_cmd_v_o)
  );

endmodule
